// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe: 3-stage normalise / round / pack back end of the FP add/sub datapath.
//   Parameters: EXP_W exponent field width, MAN_W fraction width (hidden bit excluded).
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     i_in_valid        input beat valid
//     o_in_ready        block can accept a beat
//     i_in_mant         {carry, hidden, frac, G, R, S} unsigned magnitude
//     i_in_exp          biased exponent of the larger operand
//     i_in_sign         result sign
//     i_rnd_mode        rounding mode (only when FP_RND_MODE_EN is defined)
//     o_out_valid       output beat valid
//     i_out_ready       downstream accepts beat
//     o_out_data        {sign, exp, frac}
//     o_out_flags       {overflow, underflow, inexact}
//   Optional feature macro: FP_RND_MODE_EN (selectable rounding modes; default fixed RNE).
module fp_norm_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [MAN_W+4:0]       i_in_mant,
    input  logic [EXP_W-1:0]       i_in_exp,
    input  logic                   i_in_sign,
`ifdef FP_RND_MODE_EN
    input  logic [1:0]             i_rnd_mode,
`endif
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [EXP_W+MAN_W:0]   o_out_data,
    output logic [2:0]             o_out_flags
);
    localparam int MW = MAN_W + 5;
    localparam int EW = EXP_W + 2;
    localparam int NW = MAN_W + 3;
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    logic                 w_en1, w_en2, w_en3;
    logic                 r1_valid, r1_sign, r1_zero;
    logic signed [EW-1:0] r1_exp;
    logic [NW-1:0]        r1_n;
    logic                 r2_valid, r2_sign, r2_zero, r2_inex;
    logic signed [EW-1:0] r2_exp;
    logic [MAN_W:0]       r2_frac;
    logic [EW-1:0]        w1_lz;
    logic [NW-1:0]        w1_sh, w1_n;
    logic signed [EW-1:0] w1_e0, w1_exp;
    logic                 w2_inex, w2_rne, w2_up;
    logic [MAN_W:0]       w2_frac;
    logic signed [EW-1:0] w3_exp;
    logic                 w3_ovf, w3_unf;
    logic [EXP_W+MAN_W-1:0] w3_ovf_word, w3_body;
`ifdef FP_RND_MODE_EN
    logic [1:0]           r1_mode, r2_mode;
`endif

    // A stage loads when empty or when its current content moves on this cycle.
    assign w_en3      = !o_out_valid | i_out_ready;
    assign w_en2      = !r2_valid | w_en3;
    assign w_en1      = !r1_valid | w_en2;
    assign o_in_ready = w_en1;

    // Normalise: carry shifts right into sticky; otherwise left by the leading-zero count
    // measured from the hidden bit, with G/R/S shifting up into the fraction.
    always_comb begin
        w1_lz = '0;
        for (int i = 0; i < MW - 1; i++)
            if (i_in_mant[i]) w1_lz = EW'(MW - 2 - i);
        w1_sh  = i_in_mant[NW-1:0] << w1_lz;
        w1_e0  = {2'b00, i_in_exp};
        w1_n   = i_in_mant[MW-1] ? {i_in_mant[MW-2:2], |i_in_mant[1:0]} : w1_sh;
        w1_exp = i_in_mant[MW-1] ? w1_e0 + EW'(1) : w1_e0 - w1_lz;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r1_valid <= 1'b0;
        else if (w_en1)
            r1_valid <= i_in_valid;
        if (w_en1 & i_in_valid) begin
            r1_sign <= i_in_sign;
            r1_zero <= ~|i_in_mant;
            r1_exp  <= w1_exp;
            r1_n    <= w1_n;
`ifdef FP_RND_MODE_EN
            r1_mode <= i_rnd_mode;
`endif
        end
    end

    // Round: r1_n = {frac, G, R, S}.
    assign w2_inex = |r1_n[2:0];
    assign w2_rne  = r1_n[2] & (r1_n[1] | r1_n[0] | r1_n[3]);
`ifdef FP_RND_MODE_EN
    assign w2_up = r1_mode == 2'b00 ? w2_rne :
                   r1_mode == 2'b01 ? 1'b0 :
                   r1_mode == 2'b10 ? !r1_sign & w2_inex : r1_sign & w2_inex;
`else
    assign w2_up = w2_rne;
`endif
    assign w2_frac = {1'b0, r1_n[NW-1:3]} + (MAN_W+1)'(w2_up);

    always_ff @(posedge clk) begin
        if (rst)
            r2_valid <= 1'b0;
        else if (w_en2)
            r2_valid <= r1_valid;
        if (w_en2 & r1_valid) begin
            r2_sign <= r1_sign;
            r2_zero <= r1_zero;
            r2_exp  <= r1_exp;
            r2_frac <= w2_frac;
            r2_inex <= w2_inex;
`ifdef FP_RND_MODE_EN
            r2_mode <= r1_mode;
`endif
        end
    end

    // Post-round: a rounding carry leaves the fraction bits at zero, so only the exponent moves.
    assign w3_exp = r2_exp + EW'(r2_frac[MAN_W]);
    assign w3_ovf = !r2_zero & (w3_exp >= EMAX);
    assign w3_unf = !r2_zero & !w3_ovf & (w3_exp[EW-1] | (w3_exp == '0));
`ifdef FP_RND_MODE_EN
    // Modes rounding toward zero for this sign saturate to the largest finite value.
    assign w3_ovf_word = (r2_mode == 2'b01) | (r2_mode == 2'b10 & r2_sign) | (r2_mode == 2'b11 & !r2_sign) ?
                         {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}} : {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
    assign w3_ovf_word = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
`endif
    assign w3_body = (r2_zero | w3_unf) ? '0 : w3_ovf ? w3_ovf_word : {w3_exp[EXP_W-1:0], r2_frac[MAN_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_flags <= '0;
        end else if (w_en3) begin
            o_out_valid <= r2_valid;
            if (r2_valid) begin
                o_out_data  <= {r2_sign, w3_body};
                o_out_flags <= {w3_ovf, w3_unf, r2_inex | w3_ovf | w3_unf};
            end
        end
    end
endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// tb_fp_norm_round_pipe: directed self-checking bench for fp_norm_round_pipe (EXP_W=8, MAN_W=23).
module tb_fp_norm_round_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv = 1'b0;
    logic        ir;
    logic [27:0] mant = '0;
    logic [7:0]  ex = '0;
    logic        sg = 1'b0;
    logic        ov;
    logic        ordy = 1'b1;
    logic [31:0] od;
    logic [2:0]  of;
    int          nvec = 0;
    int          nfail = 0;
    logic [31:0] xq [4];
    int          nout;
    int          seen;
    logic        drop;

    always #5 clk = ~clk;

    fp_norm_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk),
        .rst(rst),
        .i_in_valid(iv),
        .o_in_ready(ir),
        .i_in_mant(mant),
        .i_in_exp(ex),
        .i_in_sign(sg),
`ifdef FP_RND_MODE_EN
        .i_rnd_mode(2'b00),
`endif
        .o_out_valid(ov),
        .i_out_ready(ordy),
        .o_out_data(od),
        .o_out_flags(of)
    );

    function automatic logic [27:0] mk(input logic c, input logic h, input logic [22:0] f, input logic [2:0] grs);
        return {c, h, f, grs};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [27:0] m, input logic [7:0] e, input logic s,
                        input logic [31:0] xd, input logic [2:0] xf);
        int n;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(ir), 32'd1);
        iv = 1'b1; mant = m; ex = e; sg = s;
        @(negedge clk);
        iv = 1'b0;
        n = 1;
        while (!ov && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd3);
        chk({tag, "_data"}, od, xd);
        chk({tag, "_flags"}, 32'(of), 32'(xf));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(ov), 32'd0);
        chk("rst_data", od, 32'd0);
        chk("rst_flags", 32'(of), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ir), 32'd1);

        beat("carry",     mk(1, 1, 23'h0, 3'b000),      8'h7F, 1'b0, 32'h40400000, 3'b000);
        beat("tie_odd",   mk(0, 1, 23'h1, 3'b100),      8'h7F, 1'b0, 32'h3F800002, 3'b001);
        beat("tie_even",  mk(0, 1, 23'h0, 3'b100),      8'h7F, 1'b0, 32'h3F800000, 3'b001);
        beat("rnd_up",    mk(0, 1, 23'h0, 3'b101),      8'h7F, 1'b0, 32'h3F800001, 3'b001);
        beat("rnd_carry", mk(0, 1, 23'h7FFFFF, 3'b110), 8'h7F, 1'b0, 32'h40000000, 3'b001);
        beat("overflow",  mk(1, 1, 23'h0, 3'b000),      8'hFE, 1'b0, 32'h7F800000, 3'b101);
        beat("neg_trunc", mk(0, 1, 23'h123456, 3'b011), 8'h80, 1'b1, 32'hC0123456, 3'b001);
        beat("lz1_grs",   mk(0, 0, 23'h400000, 3'b100), 8'h7F, 1'b0, 32'h3F000001, 3'b000);
        beat("cancel",    mk(0, 0, 23'h1, 3'b000),      8'h7F, 1'b0, 32'h34000000, 3'b000);
        beat("underflow", mk(0, 0, 23'h1, 3'b000),      8'h10, 1'b0, 32'h00000000, 3'b011);
        beat("zero",      28'h0,                        8'h7F, 1'b1, 32'h80000000, 3'b000);

        for (int k = 0; k < 4; k++) xq[k] = 32'h3F800000 | 32'(k + 1);
        @(negedge clk);
        ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_accept", 32'(ir), 32'd1);
            iv = 1'b1; mant = mk(0, 1, 23'(k + 1), 3'b000); ex = 8'h7F; sg = 1'b0;
            @(negedge clk);
        end
        mant = mk(0, 1, 23'd4, 3'b000);
        for (int s = 0; s < 5; s++) begin
            chk("bp_full", 32'(ir), 32'd0);
            chk("bp_hold_v", 32'(ov), 32'd1);
            chk("bp_hold_d", od, xq[0]);
            chk("bp_hold_f", 32'(of), 32'd0);
            @(negedge clk);
        end
        ordy = 1'b1;
        nout = 0;
        drop = 1'b0;
        for (int c = 0; c < 12 && nout < 4; c++) begin
            if (ov) begin
                chk("bp_order", od, xq[nout]);
                nout++;
            end
            if (iv && ir) drop = 1'b1;
            @(negedge clk);
            if (drop) iv = 1'b0;
        end
        chk("bp_count", 32'(nout), 32'd4);
        chk("bp_drained", 32'(iv), 32'd0);

        ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv = 1'b1; mant = mk(0, 1, 23'(k + 9), 3'b000); ex = 8'h7F; sg = 1'b0;
            @(negedge clk);
        end
        iv = 1'b0;
        chk("mid_valid", 32'(ov), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_v", 32'(ov), 32'd0);
        chk("mid_rst_d", od, 32'd0);
        chk("mid_rst_f", 32'(of), 32'd0);
        rst = 1'b0;
        ordy = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov) seen++;
        end
        chk("mid_discard", 32'(seen), 32'd0);
        chk("mid_ready", 32'(ir), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
